// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM encoding and
// default timing constants for a 50 MHz system clock.
package key_pkg;

    // Default timing at 50 MHz: 20 ms sample period, 1 s long-press
    localparam int unsigned KEY_CLK_DIV_20MS = 1_000_000;
    localparam int unsigned KEY_LONG_1S      = 50;

    // Per-channel FSM state
    typedef logic [1:0] key_fsm_t;
    localparam key_fsm_t ST_RELEASED = 2'd0;
    localparam key_fsm_t ST_PRESSED  = 2'd1;
    localparam key_fsm_t ST_HELD     = 2'd2;

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key debouncer bus: raw key levels in, debounced levels and event pulses out.
//   key_in      raw asynchronous key levels
//   key_state   debounced level, 1 = pressed
//   key_press   1-clk pulse on released->pressed
//   key_release 1-clk pulse on pressed->released
//   key_long    1-clk pulse once per press after the long-press hold time
//   any_event   OR of all event pulses
//   sample_tick 1-clk strobe at each sample instant
// master = key source / consumer side, slave = debouncer side.
interface key_debounce_multi_if #(
    parameter int unsigned N_KEYS = 16
);
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic              any_event;
    logic              sample_tick;

    modport master (
        output key_in,
        input  key_state, key_press, key_release, key_long, any_event, sample_tick
    );

    modport slave (
        input  key_in,
        output key_state, key_press, key_release, key_long, any_event, sample_tick
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, hold counter
// and RELEASED/PRESSED/HELD FSM, all advanced only on the shared sample tick.
//   clk, rstn   clock, async active-low reset
//   tick_i      shared sample strobe
//   key_i       raw key level
//   state_o     debounced level, 1 = pressed (registered)
//   press_o     press pulse (registered)
//   release_o   release pulse (registered)
//   long_o      long-press pulse (registered)
//   evt_c_o     next-cycle value of press|release|long (combinational)
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 3,
    parameter int unsigned LONG_TICKS     = KEY_LONG_1S,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick_i,
    input  logic key_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic evt_c_o
);

    localparam int unsigned DW = $clog2(STABLE_SAMPLES + 1);
    localparam int unsigned HW = (LONG_TICKS == 0) ? 1 : $clog2(LONG_TICKS + 1);

    logic          sync1_q, sync2_q;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    key_fsm_t      st_q, st_d;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;
    logic          smp;
    logic          qual;

    // Normalised sample: 1 = pressed regardless of pin polarity
    assign smp = sync2_q ^ ACTIVE_LOW;

    // Synchroniser, reset to the released pin level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            st_q    <= ST_RELEASED;
            state_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            st_q    <= st_d;
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
        end
    end

    // Qualification, hold counting and FSM transitions
    always_comb begin
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;
        st_d    = st_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        qual    = 1'b0;

        if (tick_i) begin
            // Any agreeing sample restarts qualification
            if (smp != state_q) begin
                if (dcnt_q == DW'(STABLE_SAMPLES - 1)) begin
                    qual   = 1'b1;
                    dcnt_d = '0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end else begin
                dcnt_d = '0;
            end

            case (st_q)
                ST_RELEASED: begin
                    if (qual) begin
                        st_d    = ST_PRESSED;
                        press_d = 1'b1;
                        hcnt_d  = '0;
                    end
                end
                ST_PRESSED: begin
                    // Release wins over long-press on the same tick
                    if (qual) begin
                        st_d   = ST_RELEASED;
                        rel_d  = 1'b1;
                        hcnt_d = '0;
                    end else if ((LONG_TICKS != 0) && (hcnt_q == HW'(LONG_TICKS - 1))) begin
                        st_d   = ST_HELD;
                        long_d = 1'b1;
                    end else if (hcnt_q != '1) begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
                ST_HELD: begin
                    if (qual) begin
                        st_d   = ST_RELEASED;
                        rel_d  = 1'b1;
                        hcnt_d = '0;
                    end
                end
                default: begin
                    st_d = ST_RELEASED;
                end
            endcase
        end

        state_d = (st_d != ST_RELEASED);
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign long_o    = long_q;
    assign evt_c_o   = press_d | rel_d | long_d;

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer: shared sample-tick divider feeding one
// key_debounce_ch per key, plus a registered any-event flag.
//   clk    system clock
//   rstn   async active-low reset
//   bus    key_debounce_multi_if slave: key_in in; key_state, key_press,
//          key_release, key_long, any_event, sample_tick out (all registered)
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS         = 16,
    parameter int unsigned CLK_DIV        = KEY_CLK_DIV_20MS,
    parameter int unsigned STABLE_SAMPLES = 3,
    parameter int unsigned LONG_TICKS     = KEY_LONG_1S,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    key_debounce_multi_if.slave  bus
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic              any_q, any_d;
    logic [N_KEYS-1:0] evt_c;
    logic [N_KEYS-1:0] state_w, press_w, rel_w, long_w;

    // Divider; tick register is high exactly while cnt_q == CLK_DIV-1
    always_comb begin
        cnt_d  = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_d == CW'(CLK_DIV - 1));
        any_d  = |evt_c;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            any_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            any_q  <= any_d;
        end
    end

    for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_ch
        key_debounce_ch #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .LONG_TICKS     (LONG_TICKS),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rstn      (rstn),
            .tick_i    (tick_q),
            .key_i     (bus.key_in[i]),
            .state_o   (state_w[i]),
            .press_o   (press_w[i]),
            .release_o (rel_w[i]),
            .long_o    (long_w[i]),
            .evt_c_o   (evt_c[i])
        );
    end

    assign bus.key_state   = state_w;
    assign bus.key_press   = press_w;
    assign bus.key_release = rel_w;
    assign bus.key_long    = long_w;
    assign bus.any_event   = any_q;
    assign bus.sample_tick = tick_q;

endmodule
